// File: rtl/uart_pkg.sv
// uart_pkg: oversample constant, baud-rate table and FSM state encoding for uart_core.
// Optional UART_PARITY_EN adds the PARITY state.
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  // Indexed by baud select: 0=9600, 1=19200, 2=57600, 3=115200.
  localparam logic [3:0][31:0] BAUD_TABLE = {32'd115200, 32'd57600, 32'd19200, 32'd9600};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

  // Rounded clock divisor for one oversample tick at the selected rate.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [1:0] sel);
    int unsigned den;
    den = OVERSAMPLE * BAUD_TABLE[sel];
    return (clk_hz + den / 2) / den;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 16x oversample tick generator; restart clears the count so a frame
// begins on a fresh tick boundary.
`timescale 1ns/1ps
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       restart,
  output logic       tick
);

  localparam int unsigned DIV_0 = baud_div(CLK_FREQ_HZ, 2'd0);
  localparam int unsigned DIV_1 = baud_div(CLK_FREQ_HZ, 2'd1);
  localparam int unsigned DIV_2 = baud_div(CLK_FREQ_HZ, 2'd2);
  localparam int unsigned DIV_3 = baud_div(CLK_FREQ_HZ, 2'd3);
  localparam int CNT_W = $clog2(DIV_0 + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_m1;

  always_comb begin
    case (baud_sel)
      2'd0:    div_m1 = CNT_W'(DIV_0 - 1);
      2'd1:    div_m1 = CNT_W'(DIV_1 - 1);
      2'd2:    div_m1 = CNT_W'(DIV_2 - 1);
      default: div_m1 = CNT_W'(DIV_3 - 1);
    endcase
  end

  // >= keeps the counter bounded if the select shrinks while idle.
  assign tick = (cnt >= div_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (restart || tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/uart_core.sv
// uart_core: independent UART transmitter and receiver with 16x oversampling.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
`timescale 1ns/1ps
`default_nettype none

module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1
`ifdef UART_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [1:0]           i_Baud_Select,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  input  logic                 i_Tx_Valid,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Serial,
  input  logic                 i_Rx_Serial,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Rx_Valid,
  output logic                 o_Rx_Frame_Err,
  output logic                 o_Rx_Parity_Err
);

  localparam logic [3:0] OS_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] OS_MID    = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  uart_state_t          tx_state, tx_state_nxt;
  logic [1:0]           tx_sel;
  logic                 tx_tick, tx_bit_end, tx_last_stop, tx_accept;
  logic [3:0]           tx_os, tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;

  assign tx_bit_end   = tx_tick && (tx_os == OS_LAST);
  assign tx_last_stop = (tx_state == ST_STOP) && tx_bit_end && (tx_bit == STOP_LAST);
  // Ready during the final stop cycle lets a new frame start with no idle gap.
  assign o_Tx_Ready   = (tx_state == ST_IDLE) || tx_last_stop;
  assign tx_accept    = i_Tx_Valid && o_Tx_Ready;

  uart_baud_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tx_baud (
    .clk(i_Clock), .rst(i_Reset), .baud_sel(tx_sel), .restart(tx_accept), .tick(tx_tick)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) tx_state <= ST_IDLE;
    else         tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    o_Tx_Serial  = 1'b1;
    case (tx_state)
      ST_IDLE:  if (tx_accept) tx_state_nxt = ST_START;
      ST_START: begin
        o_Tx_Serial = 1'b0;
        if (tx_bit_end) tx_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        o_Tx_Serial = tx_shift[0];
`ifdef UART_PARITY_EN
        if (tx_bit_end && tx_bit == DATA_LAST) tx_state_nxt = ST_PARITY;
      end
      ST_PARITY: begin
        o_Tx_Serial = tx_par;
        if (tx_bit_end) tx_state_nxt = ST_STOP;
`else
        if (tx_bit_end && tx_bit == DATA_LAST) tx_state_nxt = ST_STOP;
`endif
      end
      ST_STOP:  if (tx_last_stop) tx_state_nxt = tx_accept ? ST_START : ST_IDLE;
      default:  tx_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx_sel   <= 2'd0;
      tx_os    <= 4'd0;
      tx_bit   <= 4'd0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      if (tx_state == ST_IDLE || tx_accept) tx_sel <= i_Baud_Select;
      if (tx_accept) begin
        tx_os    <= 4'd0;
        tx_bit   <= 4'd0;
        tx_shift <= i_Tx_Data;
`ifdef UART_PARITY_EN
        tx_par   <= (^i_Tx_Data) ^ PARITY_ODD;
`endif
      end else if (tx_tick && tx_state != ST_IDLE) begin
        tx_os <= tx_os + 1'b1;
        if (tx_bit_end && tx_state == ST_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= (tx_bit == DATA_LAST) ? 4'd0 : tx_bit + 1'b1;
        end else if (tx_bit_end && tx_state == ST_STOP) begin
          tx_bit <= tx_bit + 1'b1;
        end
      end
    end
  end

  uart_state_t          rx_state, rx_state_nxt;
  logic                 rx_meta, rx_sync, rx_hold;
  logic [1:0]           rx_sel;
  logic                 rx_tick, rx_mid, rx_bit_end, rx_start_det;
  logic [3:0]           rx_os, rx_bit;
  logic [DATA_BITS-1:0] rx_shift;

  // rx_hold blocks start detection after a frame error until the line returns high.
  assign rx_start_det = (rx_state == ST_IDLE) && !rx_hold && !rx_sync;
  assign rx_mid       = rx_tick && (rx_os == OS_MID);
  assign rx_bit_end   = rx_tick && (rx_os == OS_LAST);

  uart_baud_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_rx_baud (
    .clk(i_Clock), .rst(i_Reset), .baud_sel(rx_sel), .restart(rx_start_det), .tick(rx_tick)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) rx_state <= ST_IDLE;
    else         rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      ST_IDLE:  if (rx_start_det) rx_state_nxt = ST_START;
      ST_START: begin
        if (rx_mid && rx_sync) rx_state_nxt = ST_IDLE;
        else if (rx_bit_end)   rx_state_nxt = ST_DATA;
      end
`ifdef UART_PARITY_EN
      ST_DATA:   if (rx_bit_end && rx_bit == DATA_LAST) rx_state_nxt = ST_PARITY;
      ST_PARITY: if (rx_bit_end) rx_state_nxt = ST_STOP;
`else
      ST_DATA:   if (rx_bit_end && rx_bit == DATA_LAST) rx_state_nxt = ST_STOP;
`endif
      // Leave at mid-stop so the next start edge is caught without delay.
      ST_STOP:  if (rx_mid) rx_state_nxt = ST_IDLE;
      default:  rx_state_nxt = ST_IDLE;
    endcase
  end

`ifdef UART_PARITY_EN
  logic rx_par;
`else
  assign o_Rx_Parity_Err = 1'b0;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta        <= 1'b1;
      rx_sync        <= 1'b1;
      rx_hold        <= 1'b0;
      rx_sel         <= 2'd0;
      rx_os          <= 4'd0;
      rx_bit         <= 4'd0;
      rx_shift       <= '0;
      o_Rx_Data      <= '0;
      o_Rx_Valid     <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par          <= 1'b0;
      o_Rx_Parity_Err <= 1'b0;
`endif
    end else begin
      rx_meta        <= i_Rx_Serial;
      rx_sync        <= rx_meta;
      o_Rx_Valid     <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
`ifdef UART_PARITY_EN
      o_Rx_Parity_Err <= 1'b0;
`endif
      if (rx_state == ST_IDLE) begin
        rx_sel <= i_Baud_Select;
        if (rx_sync) rx_hold <= 1'b0;
      end
      if (rx_start_det) begin
        rx_os  <= 4'd0;
        rx_bit <= 4'd0;
      end else if (rx_tick && rx_state != ST_IDLE) begin
        rx_os <= rx_os + 1'b1;
        if (rx_mid && rx_state == ST_DATA) rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
        if (rx_bit_end && rx_state == ST_DATA) rx_bit <= rx_bit + 1'b1;
`ifdef UART_PARITY_EN
        if (rx_mid && rx_state == ST_PARITY) rx_par <= rx_sync;
`endif
        if (rx_mid && rx_state == ST_STOP) begin
          o_Rx_Data      <= rx_shift;
          o_Rx_Valid     <= 1'b1;
          o_Rx_Frame_Err <= !rx_sync;
          rx_hold        <= !rx_sync;
`ifdef UART_PARITY_EN
          o_Rx_Parity_Err <= rx_par ^ (^rx_shift) ^ PARITY_ODD;
`endif
        end
      end
    end
  end

endmodule

`default_nettype wire
